control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/cr16_pkg.sv | 96 +++++++++
 rtl/control_fsm_if.sv | 41 ++++
 rtl/cond_eval.sv | 37 +++
 rtl/control_fsm.sv | 162 ++++++++++++++++
 tb/tb_control_fsm.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cr16_pkg.sv
// Shared CR16 control definitions: FSM states, opcode/extension fields, condition codes.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package cr16_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EXEC_R  = 4'd2,
        EXEC_I  = 4'd3,
        SHIFT   = 4'd4,
        LD_ADDR = 4'd5,
        LD_WB   = 4'd6,
        STORE   = 4'd7,
        JUMP    = 4'd8,
        BRANCH  = 4'd9,
        JAL     = 4'd10
    } state_t;

    // Primary opcode, instr[15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // Extension field, instr[7:4]; ALU codes share the immediate opcode values
    localparam logic [3:0] EXT_ADD   = 4'b0101;
    localparam logic [3:0] EXT_SUB   = 4'b1001;
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    // Condition codes, instr[11:8]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LO = 4'b1010;
    localparam logic [3:0] COND_HS = 4'b1011;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // DataOut select
    localparam logic [1:0] CR_SHIFT = 2'b00;
    localparam logic [1:0] CR_ALU   = 2'b01;
    localparam logic [1:0] CR_PCALU = 2'b10;
    localparam logic [1:0] CR_LINK  = 2'b11;

    // All single-bit control outputs plus the DataOut select
    typedef struct packed {
        logic       iren;
        logic       pcen;
        logic       psren;
        logic       next_instr;
        logic       store_reg;
        logic       mem_write;
        logic       write_data;
        logic       reg_write;
        logic       zero_extend;
        logic       src_b;
        logic       shift_type;
        logic       jmp_en;
        logic       branch_en;
        logic       jal_en;
        logic [1:0] choose_result;
    } ctrl_t;

    // ADD/SUB/CMP (and their immediate forms) are the only flag writers
    function automatic logic sets_flags(input logic [3:0] code);
        return (code == EXT_ADD) || (code == EXT_SUB) || (code == EXT_CMP);
    endfunction

    // Logical immediates and LUI take a zero-extended immediate
    function automatic logic is_zext_op(input logic [3:0] opc);
        return (opc == OP_ANDI) || (opc == OP_ORI) || (opc == OP_XORI) || (opc == OP_LUI);
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control bundle between the CR16 control FSM (master) and the datapath (slave).
// Latency: n/a (wires only).
// Backpressure: none; the datapath consumes every control word in the cycle it is presented.
// Signals: instr/PSR flow datapath->FSM; all enables, selects and ALUcond flow FSM->datapath.
interface control_fsm_if #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
);
    logic [WIDTH-1:0]   instr;
    logic [4:0]         PSR;
    logic               IREN;
    logic               PCEN;
    logic               PSREN;
    logic               NextInstruction;
    logic               StoreReg;
    logic               MemWrite;
    logic               WriteData;
    logic               regWrite;
    logic               ZeroExtend;
    logic               SrcB;
    logic               shiftType;
    logic [REGBITS-1:0] ALUcond;
    logic               JmpEN;
    logic               BranchEN;
    logic               JALEN;
    logic [1:0]         chooseResult;

    modport master (
        input  instr, PSR,
        output IREN, PCEN, PSREN, NextInstruction, StoreReg, MemWrite, WriteData,
               regWrite, ZeroExtend, SrcB, shiftType, ALUcond, JmpEN, BranchEN,
               JALEN, chooseResult
    );

    modport slave (
        output instr, PSR,
        input  IREN, PCEN, PSREN, NextInstruction, StoreReg, MemWrite, WriteData,
               regWrite, ZeroExtend, SrcB, shiftType, ALUcond, JmpEN, BranchEN,
               JALEN, chooseResult
    );
endinterface

// File: rtl/cond_eval.sv
// Branch/jump condition evaluation from the 4-bit condition field and PSR {N,Z,F,L,C}.
// Latency: combinational.
// Backpressure: none.
// Ports: cond_i condition field, psr_i flags, taken_o condition true.
module cond_eval
    import cr16_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [4:0] psr_i,
    output logic       taken_o
);
    logic n_flag, z_flag, f_flag, l_flag, c_flag;

    assign {n_flag, z_flag, f_flag, l_flag, c_flag} = psr_i;

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_EQ: taken_o = z_flag;
            COND_NE: taken_o = ~z_flag;
            COND_CS: taken_o = c_flag;
            COND_CC: taken_o = ~c_flag;
            COND_HI: taken_o = l_flag;
            COND_LS: taken_o = ~l_flag;
            COND_GT: taken_o = n_flag;
            COND_LE: taken_o = ~n_flag;
            COND_FS: taken_o = f_flag;
            COND_FC: taken_o = ~f_flag;
            COND_LO: taken_o = ~l_flag & ~z_flag;
            COND_HS: taken_o = l_flag | z_flag;
            COND_LT: taken_o = ~n_flag & ~z_flag;
            COND_GE: taken_o = n_flag | z_flag;
            COND_UC: taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/control_fsm.sv
// Multicycle CR16 control FSM: fetch, decode, execute/write-back with registered Moore outputs.
// Latency: 3 cycles per instruction, 4 for loads; PCEN pulses once in the last cycle.
// Backpressure: none; the sequence free-runs, reset (active-low, async) is the only stall.
// Ports: clk, reset; bus (master) carries instr/PSR in and all datapath controls out.
module control_fsm
    import cr16_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
)
(
    input  logic          clk,
    input  logic          reset,
    control_fsm_if.master bus
);
    state_t             state_q, state_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [REGBITS-1:0] alu_q, alu_d;

    logic [WIDTH-1:0]   instr_w;
    logic [3:0]         op, ext, cnd, exec_code;
    state_t             dec_state;
    logic               dec_nop;
    logic               cond_taken;
    logic               unused_instr;

    assign instr_w      = bus.instr;
    assign op           = instr_w[15:12];
    assign cnd          = instr_w[11:8];
    assign ext          = instr_w[7:4];
    assign unused_instr = ^instr_w[3:0];

    // PSR is sampled on the edge that enters BRANCH/JUMP, so later flag
    // updates cannot disturb the instruction in flight.
    cond_eval u_cond (
        .cond_i  (cnd),
        .psr_i   (bus.PSR),
        .taken_o (cond_taken)
    );

    // Instruction class; unrecognised encodings run as an EXEC_R with no writes.
    always_comb begin
        dec_state = EXEC_R;
        dec_nop   = 1'b0;
        case (op)
            OP_RTYPE: dec_state = EXEC_R;
            OP_ANDI, OP_ORI, OP_XORI, OP_ADDI,
            OP_SUBI, OP_CMPI, OP_MOVI, OP_LUI: dec_state = EXEC_I;
            OP_SHIFT: dec_state = SHIFT;
            OP_BCOND: dec_state = BRANCH;
            OP_MEM: begin
                case (ext)
                    EXT_LOAD:  dec_state = LD_ADDR;
                    EXT_STOR:  dec_state = STORE;
                    EXT_JAL:   dec_state = JAL;
                    EXT_JCOND: dec_state = JUMP;
                    default:   dec_nop   = 1'b1;
                endcase
            end
            default: dec_nop = 1'b1;
        endcase
    end

    // Next state. Out of reset the FSM sits in FETCH with IREN low; the first
    // clock re-enters FETCH with IREN high so the first fetch is a full cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = ctrl_q.iren ? DECODE : FETCH;
            DECODE:  state_d = dec_state;
            LD_ADDR: state_d = LD_WB;
            default: state_d = FETCH;
        endcase
    end

    // Outputs are decoded for the state being entered and registered with it.
    // instr is held by the instruction register from DECODE to the end of the
    // instruction, so decoding it one cycle early is safe.
    always_comb begin
        ctrl_d    = '0;
        alu_d     = '0;
        exec_code = (state_d == EXEC_R) ? ext : op;
        case (state_d)
            FETCH: begin
                ctrl_d.iren       = 1'b1;
                ctrl_d.next_instr = 1'b1;
            end
            EXEC_R, EXEC_I: begin
                ctrl_d.src_b         = (state_d == EXEC_R);
                alu_d                = REGBITS'(exec_code);
                ctrl_d.choose_result = CR_ALU;
                ctrl_d.write_data    = 1'b1;
                ctrl_d.pcen          = 1'b1;
                ctrl_d.psren         = ~dec_nop & sets_flags(exec_code);
                ctrl_d.reg_write     = ~dec_nop & (exec_code != EXT_CMP);
                ctrl_d.zero_extend   = (state_d == EXEC_I) & is_zext_op(op);
            end
            SHIFT: begin
                ctrl_d.choose_result = CR_SHIFT;
                ctrl_d.shift_type    = ~ext[0];
                ctrl_d.reg_write     = 1'b1;
                ctrl_d.write_data    = 1'b1;
                ctrl_d.pcen          = 1'b1;
            end
            LD_WB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.pcen      = 1'b1;
            end
            STORE: begin
                ctrl_d.store_reg = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.pcen      = 1'b1;
            end
            JUMP: begin
                ctrl_d.pcen   = 1'b1;
                ctrl_d.jmp_en = cond_taken;
            end
            BRANCH: begin
                ctrl_d.pcen      = 1'b1;
                ctrl_d.branch_en = cond_taken;
            end
            JAL: begin
                ctrl_d.jal_en        = 1'b1;
                ctrl_d.jmp_en        = 1'b1;
                ctrl_d.choose_result = CR_LINK;
                ctrl_d.reg_write     = 1'b1;
                ctrl_d.write_data    = 1'b1;
                ctrl_d.pcen          = 1'b1;
            end
            default: ; // DECODE and LD_ADDR drive nothing; memory address falls to regData2
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            ctrl_q  <= '0;
            alu_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
        end
    end

    assign bus.IREN            = ctrl_q.iren;
    assign bus.PCEN            = ctrl_q.pcen;
    assign bus.PSREN           = ctrl_q.psren;
    assign bus.NextInstruction = ctrl_q.next_instr;
    assign bus.StoreReg        = ctrl_q.store_reg;
    assign bus.MemWrite        = ctrl_q.mem_write;
    assign bus.WriteData       = ctrl_q.write_data;
    assign bus.regWrite        = ctrl_q.reg_write;
    assign bus.ZeroExtend      = ctrl_q.zero_extend;
    assign bus.SrcB            = ctrl_q.src_b;
    assign bus.shiftType       = ctrl_q.shift_type;
    assign bus.ALUcond         = alu_q;
    assign bus.JmpEN           = ctrl_q.jmp_en;
    assign bus.BranchEN        = ctrl_q.branch_en;
    assign bus.JALEN           = ctrl_q.jal_en;
    assign bus.chooseResult    = ctrl_q.choose_result;
endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: per-instruction expected control words are queued
// at issue time and a negedge monitor compares every cycle's outputs against the queue.
// Stimulus: directed instructions, reset inside LD_WB, then randomized instructions and flags.
module tb_control_fsm;

    typedef struct packed {
        logic       IREN;
        logic       PCEN;
        logic       PSREN;
        logic       NextInstruction;
        logic       StoreReg;
        logic       MemWrite;
        logic       WriteData;
        logic       regWrite;
        logic       ZeroExtend;
        logic       SrcB;
        logic       shiftType;
        logic       JmpEN;
        logic       BranchEN;
        logic       JALEN;
        logic [1:0] chooseResult;
        logic [3:0] ALUcond;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    control_fsm_if #(.WIDTH(16), .REGBITS(4)) bus ();

    control_fsm #(.WIDTH(16), .REGBITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    vec_t  exp_q[$];
    string tag_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    bit    done   = 1'b0;

    // Condition codes come in complementary pairs: odd code = NOT(even code).
    function automatic logic model_taken(input logic [3:0] cc, input logic [4:0] p);
        logic fn, fz, ff, fl, fc, base;
        fn = p[4]; fz = p[3]; ff = p[2]; fl = p[1]; fc = p[0];
        case (cc[3:1])
            3'd0:    base = fz;
            3'd1:    base = fc;
            3'd2:    base = fl;
            3'd3:    base = fn;
            3'd4:    base = ff;
            3'd5:    base = !fl && !fz;
            3'd6:    base = !fn && !fz;
            default: base = 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    // Reference: the full cycle-by-cycle control sequence of one instruction.
    task automatic push_instr(input logic [15:0] ins, input logic [4:0] psr,
                              input int keep, output int ncyc);
        vec_t       seq[4];
        logic [3:0] op, ext, cc, code;
        bit         is_imm, is_alu;
        op  = ins[15:12];
        cc  = ins[11:8];
        ext = ins[7:4];
        for (int i = 0; i < 4; i++) seq[i] = '0;
        seq[0].IREN = 1'b1;
        seq[0].NextInstruction = 1'b1;
        ncyc   = 3;
        is_imm = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF};
        is_alu = (op == 4'h0) || is_imm;
        if (is_alu) begin
            code = is_imm ? op : ext;
            seq[2].SrcB         = !is_imm;
            seq[2].ALUcond      = code;
            seq[2].chooseResult = 2'b01;
            seq[2].WriteData    = 1'b1;
            seq[2].PCEN         = 1'b1;
            seq[2].PSREN        = code inside {4'h5, 4'h9, 4'hB};
            seq[2].regWrite     = (code != 4'hB);
            seq[2].ZeroExtend   = is_imm && (op inside {4'h1, 4'h2, 4'h3, 4'hF});
        end else if (op == 4'h8) begin
            seq[2].shiftType = !ins[4];
            seq[2].regWrite  = 1'b1;
            seq[2].WriteData = 1'b1;
            seq[2].PCEN      = 1'b1;
        end else if (op == 4'hC) begin
            seq[2].PCEN     = 1'b1;
            seq[2].BranchEN = model_taken(cc, psr);
        end else if (op == 4'h4 && ext == 4'h0) begin
            ncyc = 4;
            seq[3].regWrite = 1'b1;
            seq[3].PCEN     = 1'b1;
        end else if (op == 4'h4 && ext == 4'h4) begin
            seq[2].StoreReg = 1'b1;
            seq[2].MemWrite = 1'b1;
            seq[2].PCEN     = 1'b1;
        end else if (op == 4'h4 && ext == 4'h8) begin
            seq[2].JALEN        = 1'b1;
            seq[2].JmpEN        = 1'b1;
            seq[2].chooseResult = 2'b11;
            seq[2].regWrite     = 1'b1;
            seq[2].WriteData    = 1'b1;
            seq[2].PCEN         = 1'b1;
        end else if (op == 4'h4 && ext == 4'hC) begin
            seq[2].PCEN  = 1'b1;
            seq[2].JmpEN = model_taken(cc, psr);
        end else begin
            // undefined: behaves as a register op that writes nothing
            seq[2].SrcB         = 1'b1;
            seq[2].ALUcond      = ext;
            seq[2].chooseResult = 2'b01;
            seq[2].WriteData    = 1'b1;
            seq[2].PCEN         = 1'b1;
        end
        for (int k = 0; k < ncyc && k < keep; k++) begin
            exp_q.push_back(seq[k]);
            tag_q.push_back($sformatf("ins%04h_cyc%0d", ins, k));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Hold reset low for nlow cycles plus the release cycle; outputs stay zero throughout.
    task automatic reset_pulse(input int nlow);
        reset = 1'b0;
        for (int i = 0; i < nlow; i++) begin
            exp_q.push_back('0);
            tag_q.push_back($sformatf("reset_low%0d", i));
            next_cycle();
        end
        reset = 1'b1;
        exp_q.push_back('0);
        tag_q.push_back("reset_release");
        next_cycle();
    endtask

    // Entered at posedge+2 of the instruction's FETCH cycle. instr is garbage during
    // FETCH (IR not yet loaded) and flags keep changing after DECODE.
    task automatic run_instr(input logic [15:0] ins, input logic [4:0] psr, input bit abort_wb);
        int n;
        push_instr(ins, psr, abort_wb ? 3 : 4, n);
        for (int k = 0; k < n; k++) begin
            if (abort_wb && k == 3) begin
                reset_pulse(1);
                return;
            end
            if (k == 0) begin
                bus.instr = 16'($urandom);
                bus.PSR   = 5'($urandom);
            end else if (k == 1) begin
                bus.instr = ins;
                bus.PSR   = psr;
            end else begin
                bus.PSR   = 5'($urandom);
            end
            next_cycle();
        end
    endtask

    // Monitor: the control word is presented every cycle; compare whenever one is expected.
    initial begin
        vec_t  act, expv;
        string tag;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                tag  = tag_q.pop_front();
                act  = {bus.IREN, bus.PCEN, bus.PSREN, bus.NextInstruction, bus.StoreReg,
                        bus.MemWrite, bus.WriteData, bus.regWrite, bus.ZeroExtend, bus.SrcB,
                        bus.shiftType, bus.JmpEN, bus.BranchEN, bus.JALEN, bus.chooseResult,
                        bus.ALUcond};
                n_cmp++;
                if (act !== expv) begin
                    n_fail++;
                    $display("FAIL %s: got %05h want %05h (IREN PCEN PSREN NI SR MW WD RW ZE SB ST JE BE JL CR[2] ALU[4])",
                             tag, act, expv);
                end
            end
        end
    end

    initial begin
        logic [15:0] ins;
        bus.instr = '0;
        bus.PSR   = '0;
        next_cycle();
        reset_pulse(2);

        run_instr(16'h0152, 5'b00000, 1'b0);   // ADD r1,r2
        run_instr(16'h4102, 5'b11111, 1'b0);   // LOAD
        run_instr(16'hC012, 5'b01000, 1'b0);   // BEQ, Z=1
        run_instr(16'hC012, 5'b10111, 1'b0);   // BEQ, Z=0
        run_instr(16'h4F85, 5'b00000, 1'b0);   // JAL with never-condition field
        run_instr(16'h7000, 5'b11111, 1'b0);   // undefined opcode
        run_instr(16'h01B2, 5'b00000, 1'b0);   // CMP: flags only
        run_instr(16'hB123, 5'b00000, 1'b0);   // CMPI
        run_instr(16'h1234, 5'b00000, 1'b0);   // ANDI zero-extend
        run_instr(16'h8140, 5'b00000, 1'b0);   // shift, instr[4]=0
        run_instr(16'h4345, 5'b00000, 1'b0);   // STORE
        run_instr(16'h4EC1, 5'b00000, 1'b0);   // JUMP unconditional
        run_instr(16'h4102, 5'b00000, 1'b1);   // LOAD with reset during LD_WB
        run_instr(16'h5107, 5'b00000, 1'b0);   // ADDI after mid-instruction reset

        for (int i = 0; i < 220; i++) begin
            ins = 16'($urandom);
            if (ins[15:12] == 4'h4 && $urandom_range(0, 3) != 0) begin
                ins[7:6] = 2'($urandom_range(0, 3));
                ins[5:4] = 2'b00;
            end
            run_instr(ins, 5'($urandom), 1'b0);
        end

        next_cycle();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        done = 1'b1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
